// File: rtl/mmio_timer.sv
// Memory-mapped timer: prescaled 32-bit up-counter with compare match, overflow,
// auto-reload and a level interrupt. Reads are combinational so a single-cycle core never stalls.
module mmio_timer #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned     PRESCALE_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic [XLEN-1:0] address,
  input  logic [XLEN-1:0] WriteData,
  output logic [XLEN-1:0] ReadData,
  output logic            sel,
  output logic            irq
);

  localparam logic [2:0] OffCtrl     = 3'd0;
  localparam logic [2:0] OffPrescale = 3'd1;
  localparam logic [2:0] OffCount    = 3'd2;
  localparam logic [2:0] OffCompare  = 3'd3;
  localparam logic [2:0] OffStatus   = 3'd4;

  // ctrl_q: {IRQ_EN, AUTO, EN}; status_q: {OVF, MATCH}
  logic [2:0]            ctrl_q, ctrl_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [XLEN-1:0]       count_q, count_d;
  logic [XLEN-1:0]       compare_q, compare_d;
  logic [1:0]            status_q, status_d;
  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;

  logic [2:0] offset;
  logic       wr_en;
  logic       tick;
  logic       match_set;
  logic       ovf_set;
  logic       en_clr;
  logic       unused_addr;

  assign sel         = (address[XLEN-1:5] == BASE_ADDR[XLEN-1:5]);
  assign offset      = address[4:2];
  assign wr_en       = sel & MemWrite;
  assign unused_addr = ^address[1:0];

  assign tick = ctrl_q[0] & (pre_cnt_q == prescale_q);
  assign irq  = ctrl_q[2] & status_q[0];

  always_comb begin
    match_set  = 1'b0;
    ovf_set    = 1'b0;
    en_clr     = 1'b0;
    count_d    = count_q;
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    compare_d  = compare_q;
    status_d   = status_q;
    pre_cnt_d  = (!ctrl_q[0] || tick) ? '0 : pre_cnt_q + PRESCALE_W'(1);

    if (tick) begin
      if (count_q == compare_q) begin
        match_set = 1'b1;
        if (ctrl_q[1]) count_d = '0;
        else           en_clr  = 1'b1;
      end else if (count_q == '1) begin
        count_d = '0;
        ovf_set = 1'b1;
      end else begin
        count_d = count_q + XLEN'(1);
      end
    end

    if (en_clr) ctrl_d[0] = 1'b0;

    // Software writes override hardware updates, except status flags set this cycle.
    if (wr_en) begin
      case (offset)
        OffCtrl:     ctrl_d     = WriteData[2:0];
        OffPrescale: prescale_d = WriteData[PRESCALE_W-1:0];
        OffCount: begin
          count_d   = WriteData;
          pre_cnt_d = '0;
        end
        OffCompare:  compare_d  = WriteData;
        OffStatus:   status_d   = status_q & ~WriteData[1:0];
        default: ;
      endcase
    end

    status_d = status_d | {ovf_set, match_set};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= '0;
      prescale_q <= '0;
      count_q    <= '0;
      compare_q  <= '1;
      status_q   <= '0;
      pre_cnt_q  <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      status_q   <= status_d;
      pre_cnt_q  <= pre_cnt_d;
    end
  end

  always_comb begin
    ReadData = '0;
    if (sel && MemRead) begin
      case (offset)
        OffCtrl:     ReadData = XLEN'(ctrl_q);
        OffPrescale: ReadData = XLEN'(prescale_q);
        OffCount:    ReadData = count_q;
        OffCompare:  ReadData = compare_q;
        OffStatus:   ReadData = XLEN'(status_q);
        default:     ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Scoreboard bench for mmio_timer: stimulus queues expected read responses, a negedge monitor
// pops and compares ReadData, sel and irq whenever a load is presented.
module tb_mmio_timer;

  localparam logic [31:0] Base = 32'h1000_0000;

  logic        clk;
  logic        rst;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        sel;
  logic        irq;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        sel;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  mmio_timer #(
    .XLEN      (32),
    .BASE_ADDR (32'h1000_0000),
    .PRESCALE_W(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .address  (address),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .sel      (sel),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %08h, expected %08h", name, act, req);
    end
  endtask

  // Monitor: a load is the DUT's output event.
  always @(negedge clk) begin
    exp_t e;
    if (MemRead) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_read: got %08h, expected no read", ReadData);
      end else begin
        e = exp_q.pop_front();
        check({e.name, ".rdata"}, ReadData, e.rdata);
        check({e.name, ".sel"}, {31'd0, sel}, {31'd0, e.sel});
        check({e.name, ".irq"}, {31'd0, irq}, {31'd0, e.irq});
      end
    end
  end

  // All bus tasks start #1 after a rising edge and occupy exactly one cycle.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    MemWrite  = 1'b1;
    address   = addr;
    WriteData = data;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp_d, input logic exp_s,
                    input logic exp_i, input string name);
    exp_t e;
    e.name  = name;
    e.rdata = exp_d;
    e.sel   = exp_s;
    e.irq   = exp_i;
    exp_q.push_back(e);
    MemRead = 1'b1;
    address = addr;
    @(posedge clk);
    #1;
    MemRead = 1'b0;
  endtask

  task automatic rdwr(input logic [31:0] addr, input logic [31:0] data,
                      input logic [31:0] exp_d, input logic exp_i, input string name);
    exp_t e;
    e.name  = name;
    e.rdata = exp_d;
    e.sel   = 1'b1;
    e.irq   = exp_i;
    exp_q.push_back(e);
    MemRead   = 1'b1;
    MemWrite  = 1'b1;
    address   = addr;
    WriteData = data;
    @(posedge clk);
    #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] reset_vals [8];
    logic [31:0] one_shot   [12];
    logic [31:0] auto_cnt   [6];
    logic        auto_irq   [6];

    reset_vals = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
    one_shot   = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
    auto_cnt   = '{0, 1, 2, 0, 1, 2};
    auto_irq   = '{0, 0, 0, 1, 1, 1};

    rst       = 1'b1;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    address   = 32'h0;
    WriteData = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state and decode window.
    for (int i = 0; i < 8; i++) rd(Base + 32'(i * 4), reset_vals[i], 1'b1, 1'b0, "reset_reg");
    rd(Base + 32'h20, 32'h0, 1'b0, 1'b0, "outside_window");

    // Field widths, reserved offsets and out-of-window writes.
    wr(Base + 32'h04, 32'hABCD_1234);
    rd(Base + 32'h04, 32'h0000_1234, 1'b1, 1'b0, "prescale_zext");
    wr(Base + 32'h14, 32'hDEAD_BEEF);
    rd(Base + 32'h14, 32'h0, 1'b1, 1'b0, "reserved_rd");
    wr(Base + 32'h28, 32'h77);
    rd(Base + 32'h08, 32'h0, 1'b1, 1'b0, "nosel_write");
    wr(Base + 32'h00, 32'hFFFF_FFF8);
    rd(Base + 32'h00, 32'h0, 1'b1, 1'b0, "ctrl_upper_bits");

    // One-shot: PRESCALE=2, COMPARE=3.
    wr(Base + 32'h04, 32'd2);
    wr(Base + 32'h0C, 32'd3);
    wr(Base + 32'h00, 32'h1);
    for (int j = 0; j < 12; j++) rd(Base + 32'h08, one_shot[j], 1'b1, 1'b0, "oneshot_count");
    rd(Base + 32'h00, 32'h0, 1'b1, 1'b0, "oneshot_en_clr");
    rd(Base + 32'h10, 32'h1, 1'b1, 1'b0, "oneshot_match");
    rd(Base + 32'h08, 32'd3, 1'b1, 1'b0, "oneshot_hold");
    wr(Base + 32'h10, 32'h3);

    // Auto-reload with interrupt: PRESCALE=0, COMPARE=2, CTRL=7.
    wr(Base + 32'h04, 32'd0);
    wr(Base + 32'h0C, 32'd2);
    wr(Base + 32'h08, 32'd0);
    wr(Base + 32'h00, 32'h7);
    for (int j = 0; j < 6; j++) rd(Base + 32'h08, auto_cnt[j], 1'b1, auto_irq[j], "auto_count");
    wr(Base + 32'h10, 32'h1);
    rd(Base + 32'h08, 32'd1, 1'b1, 1'b0, "w1c_irq_low");
    rd(Base + 32'h08, 32'd2, 1'b1, 1'b0, "w1c_irq_low2");
    rd(Base + 32'h08, 32'd0, 1'b1, 1'b1, "irq_rematch");
    rd(Base + 32'h10, 32'h1, 1'b1, 1'b1, "status_rematch");
    wr(Base + 32'h00, 32'h0);
    wr(Base + 32'h10, 32'h3);

    // Overflow and W1C priority.
    wr(Base + 32'h08, 32'hFFFF_FFFE);
    wr(Base + 32'h0C, 32'd5);
    wr(Base + 32'h00, 32'h1);
    rd(Base + 32'h08, 32'hFFFF_FFFE, 1'b1, 1'b0, "ovf_cnt0");
    rd(Base + 32'h08, 32'hFFFF_FFFF, 1'b1, 1'b0, "ovf_cnt1");
    rd(Base + 32'h08, 32'h0, 1'b1, 1'b0, "ovf_wrap");
    rd(Base + 32'h10, 32'h2, 1'b1, 1'b0, "ovf_flag");
    wr(Base + 32'h08, 32'hFFFF_FFFF);
    wr(Base + 32'h10, 32'h2);
    rd(Base + 32'h10, 32'h2, 1'b1, 1'b0, "ovf_set_beats_clr");
    wr(Base + 32'h10, 32'h1);
    rd(Base + 32'h10, 32'h2, 1'b1, 1'b0, "w1c_zero_bits");
    wr(Base + 32'h10, 32'h2);
    rd(Base + 32'h10, 32'h0, 1'b1, 1'b0, "w1c_ovf");
    // CTRL write coincides with the one-shot EN clear at COUNT==5.
    wr(Base + 32'h00, 32'h5);
    rd(Base + 32'h00, 32'h5, 1'b1, 1'b1, "ctrl_wr_wins");
    rd(Base + 32'h00, 32'h4, 1'b1, 1'b1, "oneshot_again");
    wr(Base + 32'h00, 32'h0);
    wr(Base + 32'h10, 32'h3);

    // COUNT write during a tick: PRESCALE=3.
    wr(Base + 32'h0C, 32'h1000);
    wr(Base + 32'h04, 32'd3);
    wr(Base + 32'h08, 32'd0);
    wr(Base + 32'h00, 32'h1);
    rd(Base + 32'h08, 32'd0, 1'b1, 1'b0, "pre3_cnt0");
    idle(3);
    rd(Base + 32'h08, 32'd1, 1'b1, 1'b0, "pre3_cnt1");
    idle(2);
    rdwr(Base + 32'h08, 32'h100, 32'd1, 1'b0, "rd_during_wr");
    for (int j = 0; j < 4; j++) rd(Base + 32'h08, 32'h100, 1'b1, 1'b0, "cnt_wr_beats_tick");
    rd(Base + 32'h08, 32'h101, 1'b1, 1'b0, "cnt_after_wr");

    // Reset mid-count with a concurrent COMPARE write.
    wr(Base + 32'h08, 32'h40);
    rst = 1'b1;
    wr(Base + 32'h0C, 32'h55);
    rst = 1'b0;
    rd(Base + 32'h08, 32'h0, 1'b1, 1'b0, "rst_count");
    rd(Base + 32'h0C, 32'hFFFF_FFFF, 1'b1, 1'b0, "rst_compare");
    rd(Base + 32'h00, 32'h0, 1'b1, 1'b0, "rst_ctrl");
    rd(Base + 32'h04, 32'h0, 1'b1, 1'b0, "rst_prescale");
    rd(Base + 32'h10, 32'h0, 1'b1, 1'b0, "rst_status");

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
